// File: rtl/picorv_mem_xbar.sv
// picorv_mem_xbar: region-decoded picorv32 memory fabric with timeout watchdog and error responder
module picorv_mem_xbar #(
    parameter int          NumSlaves     = 4,
    parameter int          RegionShift   = 28,
    parameter int          TimeoutCycles = 255,
    parameter logic [31:0] ErrorData     = 32'hDEADBEEF
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    mem_valid_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             mem_wdata_i,
    input  logic [3:0]              mem_wstrb_i,
    output logic [31:0]             mem_rdata_o,
    output logic                    mem_ready_o,
    output logic [NumSlaves-1:0]    s_valid_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_wdata_o,
    output logic [3:0]              s_wstrb_o,
    input  logic [32*NumSlaves-1:0] s_rdata_i,
    input  logic [NumSlaves-1:0]    s_ready_i,
    output logic                    err_o,
    output logic [31:0]             err_addr_o,
    output logic [15:0]             err_count_o
);
    localparam int IW = 32 - RegionShift;
    localparam int CW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NumSlaves-1:0]   valid_q, valid_d;
    logic [31:0]            addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   ready_q, ready_d, err_q, err_d;
    logic [31:0]            err_addr_q, err_addr_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic [IW-1:0]          idx;
    logic                   mapped, sel_ready;
    logic [31:0]            sel_rdata;

    assign idx       = mem_addr_i[31:RegionShift];
    assign mapped    = 33'(idx) < 33'(NumSlaves);
    // valid_q is one-hot, so masking the ready/data buses selects the active slave
    assign sel_ready = |(s_ready_i & valid_q);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NumSlaves; k++)
            sel_rdata = sel_rdata | (valid_q[k] ? s_rdata_i[32*k +: 32] : 32'h0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_valid_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    if (mapped) begin
                        valid_d = NumSlaves'(1) << idx;
                        state_d = ACCESS;
                    end else begin
                        rdata_d    = ErrorData;
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        err_addr_d = mem_addr_i;
                        err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                        state_d    = RESPOND;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (sel_ready) begin
                    valid_d = '0;
                    rdata_d = sel_rdata;
                    ready_d = 1'b1;
                    state_d = RESPOND;
                end else if (cnt_q == CW'(TimeoutCycles - 1)) begin
                    valid_d    = '0;
                    rdata_d    = ErrorData;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    state_d    = RESPOND;
                end
            end
            RESPOND: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mem_rdata_o = rdata_q;
    assign mem_ready_o = ready_q;
    assign s_valid_o   = valid_q;
    assign s_addr_o    = addr_q;
    assign s_wdata_o   = wdata_q;
    assign s_wstrb_o   = wstrb_q;
    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;
    assign err_count_o = err_cnt_q;
endmodule

// File: tb/tb_picorv_mem_xbar.sv
// tb_picorv_mem_xbar: scoreboard bench for picorv_mem_xbar (4 slaves, timeout of 8 cycles)
module tb_picorv_mem_xbar;
    logic         clk_i = 1'b0;
    logic         reset_ni = 1'b1;
    logic         mem_valid_i = 1'b0;
    logic [31:0]  mem_addr_i = '0, mem_wdata_i = '0;
    logic [3:0]   mem_wstrb_i = '0;
    logic [31:0]  mem_rdata_o;
    logic         mem_ready_o;
    logic [3:0]   s_valid_o;
    logic [31:0]  s_addr_o, s_wdata_o;
    logic [3:0]   s_wstrb_o;
    logic [127:0] s_rdata_i = {32'hBEEF_0003, 32'hCAFE_0002, 32'h1111_0001, 32'h1234_5678};
    logic [3:0]   s_ready_i = '0;
    logic         err_o;
    logic [31:0]  err_addr_o;
    logic [15:0]  err_count_o;

    typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, failures = 0;

    int lat, vcnt;
    bit stable;
    logic [31:0] rd, ea;
    logic er, pr, pe;
    logic [15:0] ec;

    picorv_mem_xbar #(.NumSlaves(4), .RegionShift(28), .TimeoutCycles(8), .ErrorData(32'hDEADBEEF)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i), .mem_rdata_o(mem_rdata_o),
        .mem_ready_o(mem_ready_o), .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i), .err_o(err_o),
        .err_addr_o(err_addr_o), .err_count_o(err_count_o));

    always #5 clk_i = ~clk_i;

    // Runs one transaction starting at cycle 0; slave mask rdy asserted at cycle rc, stray mask every cycle.
    task automatic drive(input logic [31:0] a, wd, input logic [3:0] ws, vm, rdy, stray, input int rc);
        lat = -1; vcnt = 0; stable = 1; rd = '0; er = 0; ea = '0; ec = '0;
        mem_valid_i = 1; mem_addr_i = a; mem_wdata_i = wd; mem_wstrb_i = ws;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            s_ready_i = stray | ((c == rc) ? rdy : 4'b0);
            @(negedge clk_i);
            if (s_valid_o !== 4'b0) begin
                vcnt++;
                if (s_valid_o !== vm || s_addr_o !== a || s_wdata_o !== wd || s_wstrb_o !== ws) stable = 0;
            end
            if (mem_ready_o === 1'b1) begin
                lat = c; rd = mem_rdata_o; er = err_o; ea = err_addr_o; ec = err_count_o;
            end else if (err_o !== 1'b0) stable = 0;
            @(posedge clk_i); #1;
        end
        mem_valid_i = 0; s_ready_i = '0;
        @(negedge clk_i); pr = mem_ready_o; pe = err_o;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        #2 reset_ni = 0;
        #1;
        checks++; if ({mem_ready_o, mem_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o, err_o, err_addr_o, err_count_o} !== '0) begin
            failures++; $display("FAIL reset_outputs: got rdy=%b rd=%h sv=%b sa=%h err=%b ecnt=%0d required all zero", mem_ready_o, mem_rdata_o, s_valid_o, s_addr_o, err_o, err_count_o); end
        @(posedge clk_i); @(posedge clk_i); #1 reset_ni = 1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_read();
        sb.push_back('{32'h1234_5678, 1'b0});
        drive(32'h0000_0010, 32'h0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1);
        e = sb.pop_front();
        checks++; if (lat !== 2) begin failures++; $display("FAIL read_latency: got %0d required 2", lat); end
        checks++; if (vcnt !== 1 || !stable) begin failures++; $display("FAIL read_valid: got cycles=%0d stable=%0d required 1/1", vcnt, stable); end
        checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL read_data: got %h err=%b required %h err=%b", rd, er, e.rdata, e.err); end
        checks++; if (pr !== 1'b0 || pe !== 1'b0) begin failures++; $display("FAIL read_one_pulse: got rdy=%b err=%b required 0/0", pr, pe); end
    endtask

    task automatic test_write();
        sb.push_back('{32'hCAFE_0002, 1'b0});
        drive(32'h2000_0004, 32'hA5A5_A5A5, 4'b0011, 4'b0100, 4'b0100, 4'b0000, 5);
        e = sb.pop_front();
        checks++; if (lat !== 6) begin failures++; $display("FAIL write_latency: got %0d required 6", lat); end
        checks++; if (vcnt !== 5 || !stable) begin failures++; $display("FAIL write_valid: got cycles=%0d stable=%0d required 5/1", vcnt, stable); end
        checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL write_resp: got %h err=%b required %h err=%b", rd, er, e.rdata, e.err); end
        checks++; if (pr !== 1'b0) begin failures++; $display("FAIL write_one_pulse: got %b required 0", pr); end
    endtask

    task automatic test_unmapped();
        sb.push_back('{32'hDEAD_BEEF, 1'b1});
        drive(32'h7000_0000, 32'h5555_0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1);
        e = sb.pop_front();
        checks++; if (lat !== 1) begin failures++; $display("FAIL unmapped_latency: got %0d required 1", lat); end
        checks++; if (vcnt !== 0) begin failures++; $display("FAIL unmapped_no_slave: got %0d valid cycles required 0", vcnt); end
        checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL unmapped_resp: got %h err=%b required %h err=%b", rd, er, e.rdata, e.err); end
        checks++; if (ea !== 32'h7000_0000 || ec !== 16'd1) begin failures++; $display("FAIL unmapped_errlog: got addr=%h cnt=%0d required 70000000/1", ea, ec); end
        checks++; if (pe !== 1'b0) begin failures++; $display("FAIL unmapped_err_pulse: got %b required 0", pe); end
    endtask

    task automatic test_timeout();
        sb.push_back('{32'hDEAD_BEEF, 1'b1});
        drive(32'h1000_0100, 32'h0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, -1);
        e = sb.pop_front();
        checks++; if (vcnt !== 8 || !stable) begin failures++; $display("FAIL timeout_valid: got cycles=%0d stable=%0d required 8/1", vcnt, stable); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL timeout_latency: got %0d required 9", lat); end
        checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL timeout_resp: got %h err=%b required %h err=%b", rd, er, e.rdata, e.err); end
        checks++; if (ea !== 32'h1000_0100 || ec !== 16'd2) begin failures++; $display("FAIL timeout_errlog: got addr=%h cnt=%0d required 10000100/2", ea, ec); end
    endtask

    task automatic test_coincide();
        s_rdata_i[127:96] = 32'h0BAD_F00D;
        sb.push_back('{32'h0BAD_F00D, 1'b0});
        drive(32'h3000_0008, 32'h0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 8);
        e = sb.pop_front();
        checks++; if (lat !== 9 || vcnt !== 8) begin failures++; $display("FAIL coincide_timing: got lat=%0d cycles=%0d required 9/8", lat, vcnt); end
        checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL coincide_resp: got %h err=%b required %h err=%b", rd, er, e.rdata, e.err); end
        checks++; if (err_count_o !== 16'd2) begin failures++; $display("FAIL coincide_errcnt: got %0d required 2", err_count_o); end
    endtask

    task automatic test_stray();
        sb.push_back('{32'h1234_5678, 1'b0});
        drive(32'h0000_0040, 32'h0, 4'b0000, 4'b0001, 4'b0001, 4'b1000, 3);
        e = sb.pop_front();
        checks++; if (lat !== 4 || vcnt !== 3) begin failures++; $display("FAIL stray_timing: got lat=%0d cycles=%0d required 4/3", lat, vcnt); end
        checks++; if (rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL stray_resp: got %h err=%b required %h err=%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_reset_mid();
        mem_valid_i = 1; mem_addr_i = 32'h1000_0020; mem_wdata_i = 32'h7777_8888; mem_wstrb_i = 4'b1111;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++; if (s_valid_o !== 4'b0010) begin failures++; $display("FAIL midreset_access: got %b required 0010", s_valid_o); end
        #2 reset_ni = 0;
        #1;
        checks++; if ({mem_ready_o, mem_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o, err_o, err_addr_o, err_count_o} !== '0) begin
            failures++; $display("FAIL midreset_async: got sv=%b sa=%h rd=%h ea=%h ecnt=%0d required all zero", s_valid_o, s_addr_o, mem_rdata_o, err_addr_o, err_count_o); end
        @(posedge clk_i); #1;
        mem_valid_i = 0; reset_ni = 1;
        @(posedge clk_i); #1;
        checks++; if (mem_ready_o !== 1'b0 || s_valid_o !== 4'b0) begin failures++; $display("FAIL midreset_abandon: got rdy=%b sv=%b required 0/0000", mem_ready_o, s_valid_o); end
        sb.push_back('{32'h0BAD_F00D, 1'b0});
        drive(32'h3000_0000, 32'h0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 1);
        e = sb.pop_front();
        checks++; if (lat !== 2 || rd !== e.rdata || er !== e.err) begin failures++; $display("FAIL midreset_next: got lat=%0d rd=%h err=%b required 2/%h/%b", lat, rd, er, e.rdata, e.err); end
        checks++; if (ec !== 16'd0) begin failures++; $display("FAIL midreset_errcnt: got %0d required 0", ec); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_coincide();
        test_stray();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_empty: got %0d entries required 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
